// File: rtl/shift_rr_sched_pkg.sv
// rtl/shift_rr_sched_pkg.sv - shared state type and width helper for shift_rr_sched
package shift_rr_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Index width for a requester id; never narrower than one bit.
    function automatic int gid_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/shift_rr_sched_rr_arbiter.sv
// rtl/shift_rr_sched_rr_arbiter.sv - combinational round-robin arbiter for shift_rr_sched
module rr_arbiter
    import shift_rr_sched_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int GW      = gid_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [GW-1:0]      i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [GW-1:0]      o_grant_idx,
    output logic               o_any
);

    // First requester at or after the pointer wins, wrapping past the top index.
    always_comb begin
        int            idx;
        logic [GW-1:0] idx_g;
        idx         = 0;
        idx_g       = '0;
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx   = (int'(i_rr_ptr) + i) % NUM_REQ;
            idx_g = GW'(idx);
            if (!o_any && i_req[idx_g]) begin
                o_any          = 1'b1;
                o_grant[idx_g] = 1'b1;
                o_grant_idx    = idx_g;
            end
        end
    end

endmodule

// File: rtl/shift_rr_sched.sv
// rtl/shift_rr_sched.sv - round-robin shared serializer; SHIFT_RR_SCHED_PARITY_EN appends even parity
module shift_rr_sched
    import shift_rr_sched_pkg::*;
#(
    parameter  int DATA_WIDTH = 4,
    parameter  int NUM_REQ    = 2,
    localparam int GW         = gid_width(NUM_REQ)
) (
    input  logic                               i_clk,
    input  logic                               i_reset_n_async,
    input  logic [NUM_REQ-1:0]                 i_req_valid,
    output logic [NUM_REQ-1:0]                 o_req_ready,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]                 i_req_msb_first,
    output logic                               o_ser_valid,
    output logic                               o_ser_bit,
    output logic                               o_ser_last,
    input  logic                               i_ser_ready,
    output logic [GW-1:0]                      o_grant_id,
    output logic                               o_busy
);

`ifdef SHIFT_RR_SCHED_PARITY_EN
    localparam int NBITS = DATA_WIDTH + 1;
`else
    localparam int NBITS = DATA_WIDTH;
`endif
    localparam int CW = $clog2(NBITS + 1);

    state_e                state_q, state_d;
    logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]         grant_id_q, grant_id_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  msb_first_q, msb_first_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
`ifdef SHIFT_RR_SCHED_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic [NUM_REQ-1:0]    arb_grant;
    logic [GW-1:0]         arb_idx;
    logic                  arb_any;
    logic                  data_bit;
    logic                  last_bit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req       (i_req_valid),
        .i_rr_ptr    (rr_ptr_q),
        .o_grant     (arb_grant),
        .o_grant_idx (arb_idx),
        .o_any       (arb_any)
    );

    assign data_bit   = msb_first_q ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
    assign last_bit   = (bit_cnt_q == '0);
    assign o_grant_id = grant_id_q;
    assign o_busy     = (state_q == SHIFT);

    // Next-state and handshake outputs: grant in IDLE, emit one bit per accepted cycle in SHIFT.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        shreg_d     = shreg_q;
        msb_first_d = msb_first_q;
        bit_cnt_d   = bit_cnt_q;
`ifdef SHIFT_RR_SCHED_PARITY_EN
        parity_d    = parity_q;
`endif
        o_req_ready = '0;
        o_ser_valid = 1'b0;
        o_ser_bit   = 1'b0;
        o_ser_last  = 1'b0;
        case (state_q)
            IDLE: begin
                // Ready is gated by the raw reset so no requester sees an accept while held in reset.
                if (i_reset_n_async) begin
                    o_req_ready = arb_grant;
                end
                if (arb_any) begin
                    state_d     = SHIFT;
                    shreg_d     = i_req_data[arb_idx];
                    msb_first_d = i_req_msb_first[arb_idx];
                    bit_cnt_d   = CW'(NBITS - 1);
                    grant_id_d  = arb_idx;
                    rr_ptr_d    = (arb_idx == GW'(NUM_REQ - 1)) ? '0 : arb_idx + GW'(1);
`ifdef SHIFT_RR_SCHED_PARITY_EN
                    parity_d    = ^i_req_data[arb_idx];
`endif
                end
            end
            SHIFT: begin
                o_ser_valid = 1'b1;
                o_ser_last  = last_bit;
`ifdef SHIFT_RR_SCHED_PARITY_EN
                o_ser_bit   = last_bit ? parity_q : data_bit;
`else
                o_ser_bit   = data_bit;
`endif
                if (i_ser_ready) begin
                    if (last_bit) begin
                        state_d = IDLE;
                    end else begin
                        shreg_d   = msb_first_q ? (shreg_q << 1) : (shreg_q >> 1);
                        bit_cnt_d = bit_cnt_q - CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; an asserted reset abandons any word in flight.
    always_ff @(posedge i_clk or negedge i_reset_n_async) begin
        if (!i_reset_n_async) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            shreg_q     <= '0;
            msb_first_q <= 1'b0;
            bit_cnt_q   <= '0;
`ifdef SHIFT_RR_SCHED_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            shreg_q     <= shreg_d;
            msb_first_q <= msb_first_d;
            bit_cnt_q   <= bit_cnt_d;
`ifdef SHIFT_RR_SCHED_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_shift_rr_sched.sv
// tb/tb_shift_rr_sched.sv - self-checking bench for shift_rr_sched
module tb_shift_rr_sched;

    localparam int DW = 4;
    localparam int NR = 2;
`ifdef SHIFT_RR_SCHED_PARITY_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NR-1:0]          req_valid = '0;
    logic [NR-1:0]          req_ready;
    logic [NR-1:0][DW-1:0]  req_data = '0;
    logic [NR-1:0]          msb = '0;
    logic                   ser_valid, ser_bit, ser_last, busy;
    logic                   ser_ready = 1'b0;
    logic [0:0]             gid;

    int total = 0;
    int bad   = 0;

    shift_rr_sched #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR)
    ) dut (
        .i_clk           (clk),
        .i_reset_n_async (rst_n),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_data      (req_data),
        .i_req_msb_first (msb),
        .o_ser_valid     (ser_valid),
        .o_ser_bit       (ser_bit),
        .o_ser_last      (ser_last),
        .i_ser_ready     (ser_ready),
        .o_grant_id      (gid),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: word in flight is a queue of bits still to emit; pointer and last grant as integers.
    bit m_busy = 1'b0;
    bit m_q[$];
    int m_ptr = 0;
    int m_gid = 0;

    function automatic int pick();
        for (int i = 0; i < NR; i++) begin
            int j;
            j = (m_ptr + i) % NR;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    initial begin : model
        int w;
        int b;
        bit p;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 1'b0;
                m_q.delete();
                m_ptr  = 0;
                m_gid  = 0;
            end else if (m_busy) begin
                if (ser_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_busy = 1'b0;
                end
            end else begin
                w = pick();
                if (w >= 0) begin
                    p = 1'b0;
                    for (int k = 0; k < DW; k++) begin
                        b = msb[w] ? (DW - 1 - k) : k;
                        m_q.push_back(req_data[w][b]);
                        p ^= req_data[w][b];
                    end
`ifdef SHIFT_RR_SCHED_PARITY_EN
                    m_q.push_back(p);
`endif
                    m_gid  = w;
                    m_ptr  = (w + 1) % NR;
                    m_busy = 1'b1;
                end
            end
        end
    end

    // Compare every cycle on the falling edge.
    initial begin : compare
        logic [NR-1:0] e_ready;
        logic          e_valid, e_bit, e_last;
        int            w;
        forever begin
            @(negedge clk);
            e_ready = '0;
            e_valid = 1'b0;
            e_bit   = 1'b0;
            e_last  = 1'b0;
            if (!m_busy) begin
                w = pick();
                if (rst_n && w >= 0) e_ready[w] = 1'b1;
            end else begin
                e_valid = 1'b1;
                e_bit   = m_q[0];
                e_last  = (m_q.size() == 1);
            end
            chk("m_ready", 32'(req_ready), 32'(e_ready));
            chk("m_valid", 32'(ser_valid), 32'(e_valid));
            chk("m_bit",   32'(ser_bit),   32'(e_bit));
            chk("m_last",  32'(ser_last),  32'(e_last));
            chk("m_busy",  32'(busy),      32'(e_valid));
            chk("m_gid",   32'(gid),       32'(m_gid));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        ser_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : stim
        logic [3:0] s1, s3, s6;
        logic [9:0] vpat, vexp;
        logic       eb;
        bit         r0_bits[$];
        int         n;

        do_reset();
        @(negedge clk);
        chk("rst_valid", 32'(ser_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_gid",   32'(gid),       32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        // Single MSB-first word.
        s1 = 4'b1011;
        tick();
        req_data[0] = s1; msb[0] = 1'b1; req_valid = 2'b01; ser_ready = 1'b1;
        @(negedge clk);
        chk("s1_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        for (int k = 0; k < NB; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            eb = (k < DW) ? s1[DW-1-k] : ^s1;
            chk("s1_bit",   32'(ser_bit),   32'(eb));
            chk("s1_last",  32'(ser_last),  32'(k == NB - 1));
            chk("s1_valid", 32'(ser_valid), 32'd1);
            chk("s1_gid",   32'(gid),       32'd0);
        end
        tick();
        @(negedge clk);
        chk("s1_done", 32'(ser_valid), 32'd0);

        // Round-robin alternation with both requesters held valid.
        tick();
        do_reset();
        req_data[0] = 4'hA; msb[0] = 1'b0;
        req_data[1] = 4'h5; msb[1] = 1'b1;
        req_valid = 2'b11; ser_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (ser_valid && gid == 1'b0) r0_bits.push_back(ser_bit);
            if (req_ready != '0) begin
                chk("rr_grant", 32'(req_ready[1]), 32'(n % 2));
                n++;
            end
        end
        chk("rr_count", 32'(n), 32'd4);
        chk("rr_r0len", 32'(r0_bits.size() >= 4), 32'd1);
        if (r0_bits.size() >= 4) begin
            chk("rr_r0b0", 32'(r0_bits[0]), 32'd0);
            chk("rr_r0b1", 32'(r0_bits[1]), 32'd1);
            chk("rr_r0b2", 32'(r0_bits[2]), 32'd0);
            chk("rr_r0b3", 32'(r0_bits[3]), 32'd1);
        end

        // Sink stall after the second bit.
        tick();
        do_reset();
        s3 = 4'b1100;
        req_data[0] = s3; msb[0] = 1'b1; req_valid = 2'b01; ser_ready = 1'b1;
        @(negedge clk);
        chk("st_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("st_b0", 32'(ser_bit), 32'd1);
        tick();
        @(negedge clk);
        chk("st_b1", 32'(ser_bit), 32'd1);
        tick();
        ser_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            chk("st_hold_bit",  32'(ser_bit),   32'd0);
            chk("st_hold_last", 32'(ser_last),  32'd0);
            chk("st_hold_vld",  32'(ser_valid), 32'd1);
        end
        tick();
        ser_ready = 1'b1;
        for (int k = 2; k < NB; k++) begin
            if (k > 2) tick();
            @(negedge clk);
            eb = (k < DW) ? s3[DW-1-k] : ^s3;
            chk("st_bit",  32'(ser_bit),  32'(eb));
            chk("st_last", 32'(ser_last), 32'(k == NB - 1));
        end
        tick();
        @(negedge clk);
        chk("st_done", 32'(ser_valid), 32'd0);

        // Idle, then back-to-back words from requester 1 only.
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            chk("id_valid", 32'(ser_valid), 32'd0);
        end
        tick();
        req_data[1] = 4'b0110; msb[1] = 1'b0; req_valid = 2'b10;
        @(negedge clk);
        chk("id_ready1", 32'(req_ready), 32'd2);
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            vpat[k] = ser_valid;
            vexp[k] = ((k % (NB + 1)) != NB);
        end
        chk("gap_pattern", 32'(vpat), 32'(vexp));
        tick();
        req_valid = '0;
        repeat (NB + 2) tick();

        // Reset in the middle of a word.
        s1 = 4'b1011;
        req_data[0] = s1; msb[0] = 1'b1; req_data[1] = 4'h5; req_valid = 2'b11;
        @(negedge clk);
        chk("rm_ready", 32'(req_ready), 32'd1);
        tick();
        @(negedge clk);
        chk("rm_b0", 32'(ser_bit), 32'd1);
        tick();
        @(negedge clk);
        chk("rm_b1", 32'(ser_bit), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rm_valid", 32'(ser_valid), 32'd0);
        chk("rm_busy",  32'(busy),      32'd0);
        chk("rm_last",  32'(ser_last),  32'd0);
        chk("rm_rdy",   32'(req_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rm_first", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        repeat (NB + 2) tick();

`ifdef SHIFT_RR_SCHED_PARITY_EN
        // Parity appended after the data bits.
        s6 = 4'b0111;
        req_data[0] = s6; msb[0] = 1'b1; req_valid = 2'b01; ser_ready = 1'b1;
        @(negedge clk);
        chk("par_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            eb = (k < 4) ? s6[3-k] : 1'b1;
            chk("par_bit",  32'(ser_bit),  32'(eb));
            chk("par_last", 32'(ser_last), 32'(k == 4));
        end
        tick();
`else
        s6 = '0;
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
